comparator_pipe: RTL and testbench

//   Parametrised, pipelined magnitude/equality comparator for the datapath (branch resolution, test harness).

---
 rtl/comparator_pipe_if.sv | 30 +++
 rtl/comparator_pipe.sv | 121 ++++++++++++
 tb/tb_comparator_pipe.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/comparator_pipe_if.sv
// Operand/result handshake bundle for comparator_pipe.
// The slave modport is the comparator side; the master modport is the source/consumer side.
interface comparator_pipe_if #(
   parameter int WIDTH     = 32,
   parameter int CNT_WIDTH = 16
);
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     A;
   logic [WIDTH-1:0]     B;
   logic [2:0]           Mode;
   logic                 out_valid;
   logic                 out_ready;
   logic                 Result;
   logic                 Equal;
   logic                 Less;
   logic                 LessU;
   logic                 count_clr;
   logic [CNT_WIDTH-1:0] match_count;

   modport master (
      output in_valid, A, B, Mode, out_ready, count_clr,
      input  in_ready, out_valid, Result, Equal, Less, LessU, match_count
   );

   modport slave (
      input  in_valid, A, B, Mode, out_ready, count_clr,
      output in_ready, out_valid, Result, Equal, Less, LessU, match_count
   );
endinterface

// File: rtl/comparator_pipe.sv
// Two-stage pipelined magnitude/equality comparator with valid/ready backpressure
// and a saturating tally of transferred true results.
module comparator_pipe #(
   parameter int WIDTH     = 32,
   parameter int CNT_WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   comparator_pipe_if.slave bus
);
   localparam int MSB = WIDTH - 1;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + CNT_WIDTH'(1);
   endfunction

   function automatic logic select_flag(input logic [2:0] mode, input logic eq,
                                        input logic lt, input logic ltu);
      case (mode)
         3'd0:    return eq;
         3'd1:    return ~eq;
         3'd2:    return lt;
         3'd3:    return ~lt;
         3'd4:    return ltu;
         3'd5:    return ~ltu;
         3'd6:    return ~lt & ~eq;
         default: return ~ltu & ~eq;
      endcase
   endfunction

   logic                 s1_adv;
   logic                 in_xfer;
   logic                 out_xfer;
   logic [WIDTH:0]       diff;

   logic                 vld_p1_q, vld_p1_d;
   logic                 zero_p1_q, zero_p1_d;
   logic                 borrow_p1_q, borrow_p1_d;
   logic                 sgn_p1_q, sgn_p1_d;
   logic [2:0]           mode_p1_q;

   logic                 vld_p2_q, vld_p2_d;
   logic                 res_p2_q, res_p2_d;
   logic                 eq_p2_q, eq_p2_d;
   logic                 lt_p2_q, lt_p2_d;
   logic                 ltu_p2_q, ltu_p2_d;

   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

   assign s1_adv       = !vld_p2_q || bus.out_ready;
   assign bus.in_ready = !vld_p1_q || s1_adv;
   assign in_xfer      = bus.in_valid && bus.in_ready;
   assign out_xfer     = vld_p2_q && bus.out_ready;

   // Stage 1: one unsigned subtract yields zero, borrow and (with the MSBs) signed less.
   assign diff        = {1'b0, bus.A} - {1'b0, bus.B};
   assign zero_p1_d   = (diff[MSB:0] == '0);
   assign borrow_p1_d = diff[WIDTH];
   assign sgn_p1_d    = (bus.A[MSB] ^ bus.B[MSB]) ? bus.A[MSB] : diff[MSB];

   always_comb begin
      vld_p1_d = vld_p1_q;
      if (bus.in_ready) vld_p1_d = bus.in_valid;

      // Stage 2: flags and selected result update only when the output slot frees up.
      vld_p2_d = vld_p2_q;
      res_p2_d = res_p2_q;
      eq_p2_d  = eq_p2_q;
      lt_p2_d  = lt_p2_q;
      ltu_p2_d = ltu_p2_q;
      if (s1_adv) begin
         vld_p2_d = vld_p1_q;
         if (vld_p1_q) begin
            eq_p2_d  = zero_p1_q;
            lt_p2_d  = sgn_p1_q;
            ltu_p2_d = borrow_p1_q;
            res_p2_d = select_flag(mode_p1_q, zero_p1_q, sgn_p1_q, borrow_p1_q);
         end
      end

      cnt_d = cnt_q;
      if (bus.count_clr)            cnt_d = '0;
      else if (out_xfer && res_p2_q) cnt_d = sat_inc(cnt_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1_q <= 1'b0;
         vld_p2_q <= 1'b0;
         res_p2_q <= 1'b0;
         eq_p2_q  <= 1'b0;
         lt_p2_q  <= 1'b0;
         ltu_p2_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         vld_p1_q <= vld_p1_d;
         vld_p2_q <= vld_p2_d;
         res_p2_q <= res_p2_d;
         eq_p2_q  <= eq_p2_d;
         lt_p2_q  <= lt_p2_d;
         ltu_p2_q <= ltu_p2_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (in_xfer) begin
         zero_p1_q   <= zero_p1_d;
         borrow_p1_q <= borrow_p1_d;
         sgn_p1_q    <= sgn_p1_d;
         mode_p1_q   <= bus.Mode;
      end
   end

   assign bus.out_valid   = vld_p2_q;
   assign bus.Result      = res_p2_q;
   assign bus.Equal       = eq_p2_q;
   assign bus.Less        = lt_p2_q;
   assign bus.LessU       = ltu_p2_q;
   assign bus.match_count = cnt_q;
endmodule

// File: tb/tb_comparator_pipe.sv
// Scoreboard bench for comparator_pipe: a behavioural model predicts each accepted pair,
// results and the saturating counter are checked as they leave the pipeline.
module tb_comparator_pipe;
   localparam int W  = 32;
   localparam int CW = 2;

   logic clk;
   logic rst;

   comparator_pipe_if #(.WIDTH(W), .CNT_WIDTH(CW)) bus ();

   comparator_pipe #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int            checks;
   int            errors;
   logic [3:0]    sb[$];
   logic          got_q[$];
   logic [CW-1:0] exp_cnt;
   logic          stalled;
   logic [4:0]    held;
   logic          last_xfer;
   logic          saw_not_ready;
   int            ready_mode;
   int            cyc;

   // {Result, Equal, Less, LessU}
   function automatic logic [3:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [2:0] m);
      logic eq, lt, ltu, r;
      eq  = (a == b);
      lt  = ($signed(a) < $signed(b));
      ltu = (a < b);
      case (m)
         3'd0: r = eq;
         3'd1: r = !eq;
         3'd2: r = lt;
         3'd3: r = !lt;
         3'd4: r = ltu;
         3'd5: r = !ltu;
         3'd6: r = ($signed(a) > $signed(b));
         default: r = (a > b);
      endcase
      return {r, eq, lt, ltu};
   endfunction

   task automatic tick();
      logic [3:0] e;
      logic       exp_res;
      if (ready_mode == 1) bus.out_ready = !(cyc >= 3 && cyc <= 6);
      else if (ready_mode == 2) bus.out_ready = 1'($urandom_range(0, 1));
      cyc++;
      @(negedge clk);
      last_xfer = 1'b0;
      if (rst) begin
         sb.delete();
         exp_cnt = '0;
         stalled = 1'b0;
      end else begin
         checks++;
         if (bus.match_count !== exp_cnt) begin
            errors++;
            $display("FAIL match_count got %0d want %0d", bus.match_count, exp_cnt);
         end
         if (stalled) begin
            checks++;
            if ({bus.out_valid, bus.Result, bus.Equal, bus.Less, bus.LessU} !== held) begin
               errors++;
               $display("FAIL stall_hold got %b want %b",
                        {bus.out_valid, bus.Result, bus.Equal, bus.Less, bus.LessU}, held);
            end
         end
         exp_res = 1'b0;
         if (bus.out_valid && bus.out_ready) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_result got out_valid=1 want no pending result");
            end else begin
               e = sb.pop_front();
               exp_res = e[3];
               got_q.push_back(bus.Result);
               if ({bus.Result, bus.Equal, bus.Less, bus.LessU} !== e) begin
                  errors++;
                  $display("FAIL result_flags got %b want %b",
                           {bus.Result, bus.Equal, bus.Less, bus.LessU}, e);
               end
            end
         end
         if (bus.count_clr) exp_cnt = '0;
         else if (exp_res && exp_cnt != {CW{1'b1}}) exp_cnt = exp_cnt + 1'b1;
         if (!bus.in_ready) saw_not_ready = 1'b1;
         if (bus.in_valid && bus.in_ready) begin
            sb.push_back(model(bus.A, bus.B, bus.Mode));
            last_xfer = 1'b1;
         end
         stalled = bus.out_valid && !bus.out_ready;
         held    = {bus.out_valid, bus.Result, bus.Equal, bus.Less, bus.LessU};
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] m);
      int n;
      n = 0;
      bus.in_valid = 1'b1;
      bus.A = a;
      bus.B = b;
      bus.Mode = m;
      do begin
         tick();
         n++;
      end while (!last_xfer && n < 50);
      if (!last_xfer) begin
         checks++;
         errors++;
         $display("FAIL send_timeout got in_ready=0 for %0d cycles want transfer", n);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      bus.in_valid = 1'b0;
      ready_mode = 0;
      bus.out_ready = 1'b1;
      while ((sb.size() != 0 || bus.out_valid) && n < 100) begin
         tick();
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending want 0", sb.size());
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.A = '0; bus.B = '0; bus.Mode = '0;
      bus.out_ready = 1'b1; bus.count_clr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({bus.out_valid, bus.Result, bus.Equal, bus.Less, bus.LessU} !== 5'b0 ||
          bus.match_count !== '0) begin
         errors++;
         $display("FAIL reset_state got %b/%0d want 00000/0",
                  {bus.out_valid, bus.Result, bus.Equal, bus.Less, bus.LessU}, bus.match_count);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
      end
   endtask

   task automatic test_basic();
      send(32'd5, 32'd5, 3'd0);
      bus.in_valid = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL latency_early got out_valid=%b want 0", bus.out_valid);
      end
      tick();
      checks++;
      if ({bus.out_valid, bus.Result, bus.Equal} !== 3'b111) begin
         errors++;
         $display("FAIL basic_eq got %b want 111", {bus.out_valid, bus.Result, bus.Equal});
      end
      tick();
      checks++;
      if (bus.match_count !== 2'd1) begin
         errors++;
         $display("FAIL basic_count got %0d want 1", bus.match_count);
      end
   endtask

   task automatic test_modes();
      logic [7:0] want;
      want = 8'b1010_0110;
      got_q.delete();
      for (int m = 0; m < 8; m++) send(32'hFFFF_FFFF, 32'd1, 3'(m));
      drain();
      checks++;
      if (got_q.size() != 8) begin
         errors++;
         $display("FAIL modes_count got %0d want 8", got_q.size());
      end else begin
         for (int m = 0; m < 8; m++) begin
            checks++;
            if (got_q[m] !== want[m]) begin
               errors++;
               $display("FAIL mode_%0d got %b want %b", m, got_q[m], want[m]);
            end
         end
      end
   endtask

   task automatic test_stall();
      got_q.delete();
      saw_not_ready = 1'b0;
      cyc = 0;
      ready_mode = 1;
      for (int k = 0; k < 8; k++) send(32'(k * 3), 32'd5, 3'(k));
      drain();
      checks++;
      if (saw_not_ready !== 1'b1 || got_q.size() != 8) begin
         errors++;
         $display("FAIL stall_flow got not_ready=%b results=%0d want 1/8",
                  saw_not_ready, got_q.size());
      end
   endtask

   task automatic test_counter();
      bus.count_clr = 1'b1;
      tick();
      bus.count_clr = 1'b0;
      for (int k = 0; k < 5; k++) send(32'(k + 10), 32'(k + 10), 3'd0);
      drain();
      checks++;
      if (bus.match_count !== 2'd3) begin
         errors++;
         $display("FAIL count_sat got %0d want 3", bus.match_count);
      end
      send(32'd9, 32'd9, 3'd0);
      bus.in_valid = 1'b0;
      tick();
      bus.count_clr = 1'b1;
      tick();
      bus.count_clr = 1'b0;
      checks++;
      if (bus.match_count !== 2'd0) begin
         errors++;
         $display("FAIL count_clr_prio got %0d want 0", bus.match_count);
      end
      drain();
   endtask

   task automatic test_boundary();
      send(32'h8000_0000, 32'h7FFF_FFFF, 3'd2);
      send(32'h8000_0000, 32'h7FFF_FFFF, 3'd4);
      send(32'h8000_0000, 32'h8000_0000, 3'd0);
      send(32'h8000_0000, 32'h8000_0000, 3'd2);
      send(32'h7FFF_FFFF, 32'h8000_0000, 3'd6);
      send(32'h0000_0000, 32'hFFFF_FFFF, 3'd7);
      drain();
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] a, b;
      ready_mode = 2;
      for (int k = 0; k < 40; k++) begin
         a = $urandom();
         case ($urandom_range(0, 3))
            0: b = a;
            1: b = a + 1;
            2: b = a - 1;
            default: b = $urandom();
         endcase
         send(a, b, 3'($urandom_range(0, 7)));
      end
      drain();
   endtask

   task automatic test_reset_flight();
      send(32'd7, 32'd7, 3'd0);
      drain();
      send(32'd1, 32'd2, 3'd2);
      send(32'd3, 32'd3, 3'd0);
      bus.in_valid = 1'b0;
      rst = 1'b1;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.match_count !== '0) begin
         errors++;
         $display("FAIL reset_flight got out_valid=%b count=%0d want 0/0",
                  bus.out_valid, bus.match_count);
      end
      tick();
      tick();
      rst = 1'b0;
      repeat (5) tick();
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL stale_result got out_valid=%b want 0", bus.out_valid);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      exp_cnt = '0;
      stalled = 1'b0;
      held = '0;
      last_xfer = 1'b0;
      saw_not_ready = 1'b0;
      ready_mode = 0;
      cyc = 0;
      test_reset();
      test_basic();
      test_modes();
      test_stall();
      test_counter();
      test_boundary();
      test_back_to_back();
      test_reset_flight();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
